// File: rtl/onedconv_tile_sequencer.sv
// Tile-level loop sequencer for the 1D convolution engine: derives L_out and tile counts, then walks filter/output/channel tiles.
// Optional feature: define ONEDCONV_SEQ_PERF_EN to add the perf_stall handshake-stall counter output.
module onedconv_tile_sequencer #(
  parameter int DIM            = 16,
  parameter int ADDRESS_LENGTH = 10,
  parameter int CH_W           = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 stride,
  input  logic [2:0]                 padding,
  input  logic [4:0]                 kernel_size,
  input  logic [CH_W-1:0]            input_channels,
  input  logic [CH_W-1:0]            filter_number,
  input  logic [CH_W-1:0]            temporal_length,
  output logic                       weight_req,
  input  logic                       weight_ack,
  output logic                       tile_start,
  input  logic                       tile_done,
  output logic signed [CH_W:0]       ifmap_pos,
  output logic [ADDRESS_LENGTH-1:0]  weight_base,
  output logic [ADDRESS_LENGTH-1:0]  output_base,
  output logic [CH_W-1:0]            filter_tile,
  output logic [CH_W-1:0]            chan_tile,
  output logic [$clog2(DIM):0]       valid_cols,
  output logic                       accumulate,
  output logic                       last_chan,
  output logic                       busy,
  output logic                       done_filter,
  output logic                       done,
  output logic                       err
`ifdef ONEDCONV_SEQ_PERF_EN
  ,output logic [31:0]               perf_stall
`endif
);

  localparam int LG = $clog2(DIM);
  localparam int NW = CH_W + 2;
  localparam int VW = LG + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_TILES, S_WREQ, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]           stride_reg;
  logic [2:0]           pad_reg;
  logic [4:0]           k_reg;
  logic [CH_W-1:0]      c_num_reg, f_num_reg;
  logic signed [NW-1:0] rem_reg;
  logic [NW-1:0]        lout_reg, ot_reg, o_reg;
  logic [CH_W-1:0]      ft_reg, ct_reg, f_reg, c_reg;
  logic                 err_reg;

  logic signed [NW-1:0] n_start;
  logic                 calc_err, rem_ge, c_last, o_last, f_last, active, kill;
  logic [CH_W-1:0]      ft_calc, ct_calc;
  logic [NW-1:0]        ot_calc, o_dim, rem_cols;

  assign n_start = $signed({2'b00, temporal_length}) + $signed(NW'({padding, 1'b0}))
                 - $signed(NW'(kernel_size));

  assign calc_err = rem_reg[NW-1] || (stride_reg == 2'd0) || (c_num_reg == '0) || (f_num_reg == '0);
  assign rem_ge   = !rem_reg[NW-1] && ($unsigned(rem_reg) >= NW'(stride_reg));

  // ceil(x / DIM) as quotient plus one if any remainder bit is set
  assign ft_calc = (f_num_reg >> LG) + CH_W'(|(f_num_reg & CH_W'(DIM - 1)));
  assign ct_calc = (c_num_reg >> LG) + CH_W'(|(c_num_reg & CH_W'(DIM - 1)));
  assign ot_calc = (lout_reg >> LG) + NW'(|(lout_reg & NW'(DIM - 1)));

  assign c_last = (c_reg == ct_reg - CH_W'(1));
  assign o_last = (o_reg == ot_reg - NW'(1));
  assign f_last = (f_reg == ft_reg - CH_W'(1));
  assign kill   = abort && (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (calc_err) state_next = S_DONE;
               else if (!rem_ge) state_next = S_TILES;
      S_TILES: state_next = S_WREQ;
      S_WREQ:  if (weight_ack) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (tile_done) state_next = S_NEXT;
      S_NEXT:  if (c_last && o_last) state_next = f_last ? S_DONE : S_WREQ;
               else state_next = S_ISSUE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (kill) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || kill) begin
      stride_reg <= '0; pad_reg <= '0; k_reg <= '0;
      c_num_reg  <= '0; f_num_reg <= '0;
      rem_reg    <= '0; lout_reg <= '0;
      ft_reg <= '0; ct_reg <= '0; ot_reg <= '0;
      f_reg  <= '0; c_reg  <= '0; o_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          stride_reg <= stride;          pad_reg   <= padding;
          k_reg      <= kernel_size;     c_num_reg <= input_channels;
          f_num_reg  <= filter_number;   rem_reg   <= n_start;
          lout_reg   <= NW'(1);          err_reg   <= 1'b0;
        end
        S_CALC: if (calc_err) err_reg <= 1'b1;
                else if (rem_ge) begin
                  rem_reg  <= rem_reg - $signed(NW'(stride_reg));
                  lout_reg <= lout_reg + NW'(1);
                end
        S_TILES: begin
          ft_reg <= ft_calc; ct_reg <= ct_calc; ot_reg <= ot_calc;
          f_reg  <= '0;      c_reg  <= '0;      o_reg  <= '0;
        end
        // channel is innermost, then output position, then filter
        S_NEXT: if (c_last) begin
                  c_reg <= '0;
                  if (o_last) begin
                    o_reg <= '0;
                    f_reg <= f_last ? '0 : f_reg + CH_W'(1);
                  end else o_reg <= o_reg + NW'(1);
                end else c_reg <= c_reg + CH_W'(1);
        default: ;
      endcase
    end
  end

  assign active   = (state_reg == S_WREQ) || (state_reg == S_ISSUE) ||
                    (state_reg == S_WAIT) || (state_reg == S_NEXT);
  assign o_dim    = o_reg << LG;
  assign rem_cols = lout_reg - o_dim;

  assign weight_req  = (state_reg == S_WREQ);
  assign tile_start  = (state_reg == S_ISSUE);
  assign busy        = (state_reg != S_IDLE);
  assign done_filter = (state_reg == S_NEXT) && c_last && o_last;
  assign done        = (state_reg == S_DONE);
  assign err         = err_reg;

  // tile fields are zeroed outside the tile loop so IDLE always shows reset values
  assign ifmap_pos   = active ? ((CH_W+1)'(o_dim) * (CH_W+1)'(stride_reg) - (CH_W+1)'(pad_reg)) : '0;
  assign weight_base = active ? (ADDRESS_LENGTH'(c_reg) * ADDRESS_LENGTH'(k_reg)) : '0;
  assign output_base = active ? ADDRESS_LENGTH'(o_dim) : '0;
  assign filter_tile = active ? f_reg : '0;
  assign chan_tile   = active ? c_reg : '0;
  assign valid_cols  = !active ? '0 : (rem_cols >= NW'(DIM)) ? VW'(DIM) : VW'(rem_cols);
  assign accumulate  = active && (c_reg != '0);
  assign last_chan   = active && c_last;

`ifdef ONEDCONV_SEQ_PERF_EN
  logic [31:0] perf_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || kill)
      perf_reg <= '0;
    else if ((state_reg == S_IDLE) && start)
      perf_reg <= '0;
    else if (((state_reg == S_WREQ) || (state_reg == S_WAIT)) && (perf_reg != '1))
      perf_reg <= perf_reg + 32'd1;
  end
  assign perf_stall = perf_reg;
`endif

endmodule

// File: doc/onedconv_tile_sequencer.md
# onedconv_tile_sequencer

Parametrised tile-level loop sequencer for the 1D convolution engine, the generalised successor of the fixed-geometry conv control. From runtime convolution parameters it computes output length and tile counts, walks the filter/output/channel tile nest, and runs the weight-reload handshake once per filter tile. For each tile it issues one command to the systolic compute layer and waits for completion. It sits between the host register bank and the per-tile matrix-multiplication control, replacing hard-wired 16×16 assumptions with a `DIM`-parametrised schedule plus abort and error reporting.

## Interface
Parameters:
- `DIM`, 16 — systolic tile edge. Must be a power of two, 2 to 64.
- `ADDRESS_LENGTH`, 10 — BRAM address width.
- `CH_W`, 10 — width of the channel, filter and length fields.

Ports:
- `clk` in 1 — single clock. All logic is rising-edge.
- `rst` in 1 — asynchronous, active-low reset.
- `start` in 1 — begin job. Sampled only in IDLE.
- `abort` in 1 — synchronous job cancel.
- `stride` in 2 — 1..3. Value 0 is an error.
- `padding` in 3 — zero-padding each side.
- `kernel_size` in 5 — kernel taps, 1..31.
- `input_channels` in CH_W — channel count.
- `filter_number` in CH_W — filter count.
- `temporal_length` in CH_W — input length T.
- `weight_req` out 1 — request weight reload for the current filter tile.
- `weight_ack` in 1 — weight reload complete.
- `tile_start` out 1 — one-cycle tile command strobe.
- `tile_done` in 1 — compute finished the current tile.
- `ifmap_pos` out CH_W+1 — signed first input position of the tile: o·DIM·S − P.
- `weight_base` out ADDRESS_LENGTH — c·kernel_size.
- `output_base` out ADDRESS_LENGTH — o·DIM.
- `filter_tile` out CH_W — current filter tile index f.
- `chan_tile` out CH_W — current channel tile index c.
- `valid_cols` out $clog2(DIM)+1 — valid output columns in the tile.
- `accumulate` out 1 — high when c≠0.
- `last_chan` out 1 — high when c = CT−1.
- `busy` out 1 — high from CALC through DONE.
- `done_filter` out 1 — one-cycle pulse after the last tile of each filter tile.
- `done` out 1 — one-cycle job-complete pulse.
- `err` out 1 — parameter-error flag. Held until the next accepted start.

## Operation
Derived quantities:
- N = T + 2P − K, computed at CH_W+2-bit signed width.
- L_out = floor(N/S) + 1.
- FT = ceil(F/DIM), CT = ceil(C/DIM), OT = ceil(L_out/DIM), all computed by shift/mask.

States:
- IDLE → CALC on `start`. Latch all parameters and clear `err`.
- CALC: iterative subtract. Initialise rem=N, L_out=1. Each cycle, if rem ≥ S then rem −= S and L_out++; otherwise go to TILES.
  - Parameter error → set `err`, go to DONE. Errors are: N < 0, S = 0, C = 0, F = 0.
- TILES: one cycle. Register FT, CT, OT. Zero f, o, c. Go to WREQ.
- WREQ: `weight_req` is high. On sampled `weight_ack`, go to ISSUE.
- ISSUE: drive `tile_start` for one cycle with all tile fields valid, then go to WAIT.
- WAIT: on `tile_done`, go to NEXT.
- NEXT: advance loops innermost-first.
  - c++. On c wrap, o++. On o wrap, pulse `done_filter` and f++.
  - If f wraps → DONE.
  - Else if o and c both wrapped → WREQ (new filter tile).
  - Else → ISSUE.
- DONE: pulse `done` for one cycle, then go to IDLE.

Rules:
- valid_cols = min(DIM, L_out − o·DIM).
- Tile fields hold stable from ISSUE through WAIT and change only in NEXT.
- `abort` in any non-IDLE state → IDLE next cycle. No `done`, and all outputs return to reset values.
- `abort` takes priority over every simultaneous event.
- `start` while `busy` is ignored.
- `tile_done` and `weight_ack` are ignored outside WAIT and WREQ respectively.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- start → CALC on the next edge. CALC lasts floor(N/S)+1 cycles; on error it lasts 1 cycle.
- TILES lasts 1 cycle. `weight_req` rises the cycle after TILES.
- `weight_req` deasserts the cycle after `weight_ack` is sampled high. `tile_start` fires that same cycle.
- `tile_done` sampled → NEXT → next `tile_start` 2 cycles after `tile_done`.
- `done_filter` is registered in NEXT. For the final filter tile, `done` follows 1 cycle after `done_filter`.
- Error path: `done` appears 2 cycles after `start`, with `err` = 1.

## Configuration
- `ONEDCONV_SEQ_PERF_EN` defined: adds output `perf_stall` [31:0], a saturating count of cycles spent in WREQ or WAIT. It is cleared on accepted `start` and on reset, and holds its value after `done`.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- **Basic schedule:** T=32, P=0, K=3, S=1, C=16, F=32, DIM=16.
  - L_out=30, CT=1, OT=2, FT=2.
  - `weight_req` twice, 4 `tile_start`s with valid_cols 16,14,16,14.
  - `done_filter` ×2, `done` once, `err` = 0.
- **Stride and padding:** T=32, P=1, K=4, S=2, C=40, F=16.
  - L_out=16, CT=3.
  - 3 tiles with weight_base 0,4,8; `accumulate` 0,1,1; `last_chan` only on the third; ifmap_pos = −1.
- **Parameter error:** K=9, T=4, P=0 → `err` = 1, `done` 2 cycles after `start`, no `weight_req` or `tile_start`. Repeat with S=0 → same response.
- **Handshake stall:** hold `weight_ack` low for 20 cycles and `tile_done` low for 50.
  - No spurious `tile_start` and tile fields stable throughout.
  - With PERF_EN, `perf_stall` ≥ 70.
- **Abort:** assert `abort` during WAIT of tile 2 → IDLE next cycle, all outputs 0, no `done`. A new `start` then completes normally.
- **Mid-job reset:** drop `rst` during WREQ → all outputs 0 immediately. Raise `start` after release → full schedule restarts from f=0.
